// File: rtl/rvcpu_pkg.sv
// Shared types for the rvcpu execute stage: ALU opcodes, flag/compare bundles and EX FSM states.
package rvcpu;

  typedef enum logic [2:0] {
    AluAdd = 3'd0,
    AluSll = 3'd1,
    AluSlt = 3'd2,
    AluXor = 3'd3,
    AluSrl = 3'd4,
    AluSra = 3'd5,
    AluOr  = 3'd6,
    AluAnd = 3'd7
  } alu_op_t;

  typedef struct packed {
    logic negative;
    logic zero;
    logic overflow;
    logic carry;
  } alu_flags_t;

  typedef struct packed {
    logic equal;
    logic less_than;
  } cmp_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ex_state_t;

  function automatic logic is_shift_op(alu_op_t op);
    return (op == AluSll) || (op == AluSrl) || (op == AluSra);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU: add/sub, logic ops, slt/sltu, plus flag and compare generation.
module alu_comb
  import rvcpu::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  alu_op_t          op,
  input  logic             mod,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  output logic [XLEN-1:0]  result,
  output alu_flags_t       flags,
  output cmp_t             cmp
);

  logic [XLEN-1:0] b_eff;
  logic [XLEN-1:0] sum;
  logic            sum_carry;
  logic            sum_ovf;
  logic            is_add;
  logic            use_unsigned;
  logic            less_than;

  assign is_add = (op == AluAdd);
  // Subtract is a + ~b + 1, so carry out means "no borrow".
  assign b_eff  = (is_add && mod) ? ~b : b;
  assign {sum_carry, sum} = {1'b0, a} + {1'b0, b_eff} + {{XLEN{1'b0}}, is_add & mod};
  assign sum_ovf = (a[XLEN-1] == b_eff[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);

  assign use_unsigned = (op == AluSlt) && mod;
  assign less_than    = use_unsigned ? (a < b) : ($signed(a) < $signed(b));

  always_comb begin
    result = a;
    case (op)
      AluAdd:  result = sum;
      AluSlt:  result = {{(XLEN-1){1'b0}}, less_than};
      AluXor:  result = a ^ b;
      AluOr:   result = a | b;
      AluAnd:  result = a & b;
      // Shift ops only reach here with a zero shift amount: pass a through.
      default: result = a;
    endcase
  end

  always_comb begin
    flags.negative = result[XLEN-1];
    flags.zero     = (result == '0);
    flags.overflow = is_add & sum_ovf;
    flags.carry    = is_add & sum_carry;
  end

  assign cmp.equal     = (a == b);
  assign cmp.less_than = less_than;

endmodule

// File: rtl/ex_unit.sv
// Execute unit: single-cycle ALU ops plus a bit-serial shifter, with a registered
// valid/ready result stage.
module ex_unit
  import rvcpu::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  alu_op_t         in_op,
  input  logic            in_mod,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic            in_flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output alu_flags_t      out_flags,
  output cmp_t            out_cmp,
  output logic            busy
);

  localparam int unsigned ShW = $clog2(XLEN);
  localparam logic [ShW-1:0] CountOne = ShW'(1);

  ex_state_t       state_q, state_d;
  logic [ShW-1:0]  count_q, count_d;
  logic [XLEN-1:0] shreg_q, shreg_d;
  alu_op_t         shop_q, shop_d;
  cmp_t            cmp_pend_q, cmp_pend_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] result_q, result_d;
  alu_flags_t      flags_q, flags_d;
  cmp_t            cmp_q, cmp_d;

  logic [XLEN-1:0] alu_result;
  alu_flags_t      alu_flags;
  cmp_t            alu_cmp;
  logic [ShW-1:0]  shamt;
  logic            long_shift;
  logic            accept;
  logic [XLEN-1:0] shift_next;
  alu_flags_t      shift_flags;

  alu_comb #(
    .XLEN(XLEN)
  ) u_alu (
    .op    (in_op),
    .mod   (in_mod),
    .a     (in_a),
    .b     (in_b),
    .result(alu_result),
    .flags (alu_flags),
    .cmp   (alu_cmp)
  );

  assign shamt      = in_b[ShW-1:0];
  assign long_shift = is_shift_op(in_op) && (shamt != '0);
  assign in_ready   = (state_q == IDLE) && !in_flush && (!out_valid_q || out_ready);
  assign accept     = in_valid && in_ready;
  assign busy       = (state_q == SHIFT);

  always_comb begin
    shift_next = {shreg_q[XLEN-2:0], 1'b0};
    case (shop_q)
      AluSrl:  shift_next = {1'b0, shreg_q[XLEN-1:1]};
      AluSra:  shift_next = {shreg_q[XLEN-1], shreg_q[XLEN-1:1]};
      default: shift_next = {shreg_q[XLEN-2:0], 1'b0};
    endcase
  end

  always_comb begin
    shift_flags.negative = shift_next[XLEN-1];
    shift_flags.zero     = (shift_next == '0);
    shift_flags.overflow = 1'b0;
    shift_flags.carry    = 1'b0;
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    shreg_d     = shreg_q;
    shop_d      = shop_q;
    cmp_pend_d  = cmp_pend_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    cmp_d       = cmp_q;
    if (in_flush) begin
      state_d     = IDLE;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      if (out_valid_q && out_ready) out_valid_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            if (long_shift) begin
              // Compare result is captured now; it is published with the shift result.
              shreg_d    = in_a;
              count_d    = shamt;
              shop_d     = in_op;
              cmp_pend_d = alu_cmp;
              state_d    = SHIFT;
            end else begin
              result_d    = alu_result;
              flags_d     = alu_flags;
              cmp_d       = alu_cmp;
              out_valid_d = 1'b1;
            end
          end
        end
        SHIFT: begin
          shreg_d = shift_next;
          count_d = count_q - CountOne;
          if (count_q == CountOne) begin
            result_d    = shift_next;
            flags_d     = shift_flags;
            cmp_d       = cmp_pend_q;
            out_valid_d = 1'b1;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      shreg_q     <= '0;
      shop_q      <= AluAdd;
      cmp_pend_q  <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      cmp_q       <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      shreg_q     <= shreg_d;
      shop_q      <= shop_d;
      cmp_pend_q  <= cmp_pend_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      cmp_q       <= cmp_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = result_q;
  assign out_flags  = flags_q;
  assign out_cmp    = cmp_q;

endmodule

// File: tb/tb_ex_unit.sv
// Scoreboard bench for ex_unit: directed ops push expected results, a monitor pops and compares.
module tb_ex_unit;
  import rvcpu::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  alu_op_t     in_op;
  logic        in_mod;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  alu_flags_t  out_flags;
  cmp_t        out_cmp;
  logic        busy;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  flg;
    logic [1:0]  cmp;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  ex_unit #(
    .XLEN(32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_mod    (in_mod),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_flush  (in_flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_flags (out_flags),
    .out_cmp   (out_cmp),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every handshake of a result is checked against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got %0h expected none at %0t", out_result, $time);
      end else begin
        mon_e = sb.pop_front();
        check("out_result", out_result, mon_e.res);
        check("out_flags", out_flags, mon_e.flg);
        check("out_cmp", out_cmp, mon_e.cmp);
      end
    end
  end

  // lat: -1 = no expectation pushed, 0 = single-cycle op, >0 = serial shift of that many cycles.
  task automatic issue(input alu_op_t op, input logic md, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] er, input logic [3:0] ef,
                       input logic [1:0] ec, input int lat);
    bit acc;
    acc = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_op    = op;
    in_mod   = md;
    in_a     = a;
    in_b     = b;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      if (in_ready) acc = 1'b1;
    end
    check("accept_within_bound", acc, 1);
    if (acc && lat >= 0) sb.push_back('{res: er, flg: ef, cmp: ec});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (acc && lat == 0) begin
      @(negedge clk);
      check("single_cycle_valid", out_valid, 1);
    end else if (acc && lat > 0) begin
      for (int i = 0; i < lat; i++) begin
        @(negedge clk);
        check("shift_busy", busy, 1);
        check("shift_in_ready_low", in_ready, 0);
        check("shift_no_valid", out_valid, 0);
      end
      @(negedge clk);
      check("shift_done_valid", out_valid, 1);
      check("shift_done_busy", busy, 0);
    end
  endtask

  task automatic watch_no_valid(input string name, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check(name, seen, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = AluAdd;
    in_mod    = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_flush  = 1'b0;
    out_ready = 1'b1;

    #13;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_flags", out_flags, 0);
    check("rst_out_cmp", out_cmp, 0);
    check("rst_busy", busy, 0);
    #9 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    //     op      mod   a             b             result        NZVC     {eq,lt} lat
    issue(AluAdd, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1010, 2'b00, 0);
    issue(AluAdd, 1'b1, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b0101, 2'b10, 0);
    issue(AluAdd, 1'b1, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 4'b1000, 2'b01, 0);
    issue(AluSra, 1'b0, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 4'b1000, 2'b01, 4);
    issue(AluSrl, 1'b0, 32'h8000_0000, 32'h0000_0001, 32'h4000_0000, 4'b0000, 2'b01, 1);
    issue(AluSll, 1'b0, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 4'b0000, 2'b00, 0);
    issue(AluSll, 1'b0, 32'h0000_0001, 32'h0000_0023, 32'h0000_0008, 4'b0000, 2'b01, 3);
    issue(AluSlt, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 4'b0000, 2'b01, 0);
    issue(AluSlt, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0100, 2'b00, 0);
    issue(AluOr,  1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'b0100, 2'b10, 0);

    // Stall: xor result held for 3 cycles while an and is offered, then back-to-back.
    @(posedge clk);
    #1 out_ready = 1'b0;
    issue(AluXor, 1'b0, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5, 4'b0000, 2'b01, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_op    = AluAnd;
      in_mod   = 1'b0;
      in_a     = 32'hF0F0_1234;
      in_b     = 32'h0FF0_FFFF;
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_result", out_result, 32'h5A5A_A5A5);
      check("stall_flags", out_flags, 4'b0000);
      check("stall_cmp", out_cmp, 2'b01);
      check("stall_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    check("b2b_in_ready", in_ready, 1);
    if (in_ready) sb.push_back('{res: 32'h00F0_1234, flg: 4'b0000, cmp: 2'b01});
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("b2b_valid_stays", out_valid, 1);
    check("b2b_result", out_result, 32'h00F0_1234);

    // Flush at shift cycle 10 of a 31-bit sll, with a competing op offered.
    issue(AluSll, 1'b0, 32'h0000_0001, 32'h0000_001F, 32'h0, 4'h0, 2'h0, -1);
    repeat (9) @(posedge clk);
    #1;
    in_flush = 1'b1;
    in_valid = 1'b1;
    in_op    = AluAdd;
    in_a     = 32'h1;
    in_b     = 32'h1;
    @(negedge clk);
    check("flush_in_ready_low", in_ready, 0);
    check("flush_busy_before", busy, 1);
    @(posedge clk);
    #1;
    in_flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_idle", busy, 0);
    check("flush_no_valid_now", out_valid, 0);
    check("flush_in_ready_back", in_ready, 1);
    watch_no_valid("flush_no_valid_later", 40);

    // Asynchronous reset mid-shift.
    issue(AluSll, 1'b0, 32'h0000_0001, 32'h0000_001F, 32'h0, 4'h0, 2'h0, -1);
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_result", out_result, 0);
    check("midrst_out_flags", out_flags, 0);
    check("midrst_out_cmp", out_cmp, 0);
    check("midrst_busy", busy, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    watch_no_valid("midrst_no_valid_later", 40);

    issue(AluAdd, 1'b0, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 4'b0000, 2'b01, 0);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
